button_conditioner: RTL and testbench

- Upstream stage of the game controller.
- Takes raw, bouncing FPGA push-button inputs (up, down, left, right, center) and produces clean signals for the controller FSMs:
  - synchronized, debounced button levels;
  - single-cycle press pulses;
  - single-cycle release pulses.
- One instance per board, clocked on the same clock as the controller.

---
 rtl/button_conditioner_if.sv | 27 ++
 rtl/button_conditioner.sv | 95 +++++++++
 tb/tb_button_conditioner.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
// Push-button bundle between the raw board pins, the conditioner and the game controller.
// The conditioner plugs in as slave; whoever drives the raw pins and reads the results is master.
interface button_conditioner_if #(
  parameter int NUM_BTN = 5
);
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic               any_level;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  any_level
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output any_level
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronizes and debounces the board push-buttons, giving clean levels plus
// one-cycle press/release pulses per channel for the controller FSMs.
module button_conditioner #(
  parameter int NUM_BTN   = 5,
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = 20
) (
  input  logic                clk,
  input  logic                rst,
  button_conditioner_if.slave btn
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CHK_HI = 2'd1;
  localparam logic [1:0] HIGH   = 2'd2;
  localparam logic [1:0] CHK_LO = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] level_q;
  logic [NUM_BTN-1:0] press_q;
  logic [NUM_BTN-1:0] release_q;
  logic [1:0]         state [NUM_BTN];
  logic [CNT_W-1:0]   cnt   [NUM_BTN];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1     <= '0;
      sync2     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      sync1     <= btn.btn_raw;
      sync2     <= sync1;
      press_q   <= '0;
      release_q <= '0;
      // Each channel only accepts a new level after DB_CYCLES identical sync2 samples.
      for (int i = 0; i < NUM_BTN; i++) begin
        case (state[i])
          IDLE: begin
            if (sync2[i]) begin
              state[i] <= CHK_HI;
              cnt[i]   <= '0;
            end
          end
          CHK_HI: begin
            if (!sync2[i]) begin
              state[i] <= IDLE;
            end else if (cnt[i] == CNT_LAST) begin
              state[i]   <= HIGH;
              level_q[i] <= 1'b1;
              press_q[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
          HIGH: begin
            if (!sync2[i]) begin
              state[i] <= CHK_LO;
              cnt[i]   <= '0;
            end
          end
          CHK_LO: begin
            if (sync2[i]) begin
              state[i] <= HIGH;
            end else if (cnt[i] == CNT_LAST) begin
              state[i]     <= IDLE;
              level_q[i]   <= 1'b0;
              release_q[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
          default: begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

  assign btn.btn_level   = level_q;
  assign btn.btn_press   = press_q;
  assign btn.btn_release = release_q;
  assign btn.any_level   = |level_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a short debounce window (4 samples),
// so every latency below is 6 edges after the first sampling edge.
module tb_button_conditioner;
  localparam int NB = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int total = 0;
  int bad   = 0;
  int press_cnt [NB];
  int rel_cnt   [NB];
  int overlap   = 0;
  int snap_p;
  int snap_r;

  button_conditioner_if #(.NUM_BTN(NB)) bif ();

  button_conditioner #(
    .NUM_BTN   (NB),
    .DB_CYCLES (4),
    .CNT_W     (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .btn (bif)
  );

  always #5 clk = ~clk;

  // Pulse tally on the falling edge, well away from the register updates.
  always @(negedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (bif.btn_press[i])   press_cnt[i]++;
      if (bif.btn_release[i]) rel_cnt[i]++;
      if (bif.btn_press[i] && bif.btn_release[i]) overlap++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < NB; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
    end
    bif.btn_raw = 5'b11111;
    rst = 1'b0;

    applyStimulus(3);
    checkOutput("rst_level",   32'(bif.btn_level),   32'h0);
    checkOutput("rst_press",   32'(bif.btn_press),   32'h0);
    checkOutput("rst_release", 32'(bif.btn_release), 32'h0);
    checkOutput("rst_any",     32'(bif.any_level),   32'h0);
    applyStimulus(2);
    checkOutput("rst_hold_level", 32'(bif.btn_level), 32'h0);

    rst = 1'b1;
    applyStimulus(6);
    checkOutput("rst_rel_press_early", 32'(bif.btn_press), 32'h0);
    applyStimulus(1);
    checkOutput("rst_rel_press", 32'(bif.btn_press), 32'h1f);
    applyStimulus(1);
    checkOutput("rst_rel_press_gone", 32'(bif.btn_press), 32'h0);
    checkOutput("rst_rel_level",      32'(bif.btn_level), 32'h1f);
    checkOutput("rst_rel_any",        32'(bif.any_level), 32'h1);
    bif.btn_raw = 5'b00000;
    applyStimulus(6);
    checkOutput("all_rel_early", 32'(bif.btn_release), 32'h0);
    checkOutput("all_rel_held",  32'(bif.btn_level),   32'h1f);
    applyStimulus(1);
    checkOutput("all_rel_pulse", 32'(bif.btn_release), 32'h1f);
    checkOutput("all_rel_level", 32'(bif.btn_level),   32'h0);
    checkOutput("all_rel_any",   32'(bif.any_level),   32'h0);
    applyStimulus(1);
    checkOutput("all_rel_gone", 32'(bif.btn_release), 32'h0);

    // Clean press/release on right
    snap_p = press_cnt[3];
    bif.btn_raw = 5'b01000;
    applyStimulus(6);
    checkOutput("right_press_early", 32'(bif.btn_press), 32'h0);
    applyStimulus(1);
    checkOutput("right_press", 32'(bif.btn_press), 32'h08);
    applyStimulus(1);
    checkOutput("right_press_gone", 32'(bif.btn_press), 32'h0);
    checkOutput("right_level",      32'(bif.btn_level), 32'h08);
    applyStimulus(12);
    checkOutput("right_level_hold", 32'(bif.btn_level), 32'h08);
    bif.btn_raw = 5'b00000;
    applyStimulus(6);
    checkOutput("right_rel_early", 32'(bif.btn_release), 32'h0);
    checkOutput("right_rel_held",  32'(bif.btn_level),   32'h08);
    applyStimulus(1);
    checkOutput("right_rel", 32'(bif.btn_release), 32'h08);
    applyStimulus(1);
    checkOutput("right_rel_gone", 32'(bif.btn_release), 32'h0);
    checkOutput("right_level_low", 32'(bif.btn_level),  32'h0);
    checkOutput("right_press_once", 32'(press_cnt[3] - snap_p), 32'd1);

    // Bounce on up
    snap_p = press_cnt[0];
    bif.btn_raw = 5'b00001; applyStimulus(1);
    bif.btn_raw = 5'b00000; applyStimulus(1);
    bif.btn_raw = 5'b00001; applyStimulus(1);
    bif.btn_raw = 5'b00000; applyStimulus(1);
    bif.btn_raw = 5'b00001;
    applyStimulus(6);
    checkOutput("bounce_no_press", 32'(press_cnt[0] - snap_p), 32'd0);
    checkOutput("bounce_level_low", 32'(bif.btn_level), 32'h0);
    applyStimulus(1);
    checkOutput("bounce_press", 32'(bif.btn_press), 32'h01);
    applyStimulus(1);
    checkOutput("bounce_level", 32'(bif.btn_level), 32'h01);
    bif.btn_raw = 5'b00000;
    applyStimulus(8);
    checkOutput("bounce_released",   32'(bif.btn_level), 32'h0);
    checkOutput("bounce_press_once", 32'(press_cnt[0] - snap_p), 32'd1);

    // Release glitch on right while held
    bif.btn_raw = 5'b01000;
    applyStimulus(8);
    checkOutput("glitch_level_up", 32'(bif.btn_level), 32'h08);
    snap_p = press_cnt[3];
    snap_r = rel_cnt[3];
    bif.btn_raw = 5'b00000;
    applyStimulus(3);
    bif.btn_raw = 5'b01000;
    applyStimulus(10);
    checkOutput("glitch_level",      32'(bif.btn_level), 32'h08);
    checkOutput("glitch_no_release", 32'(rel_cnt[3] - snap_r),   32'd0);
    checkOutput("glitch_no_press",   32'(press_cnt[3] - snap_p), 32'd0);
    bif.btn_raw = 5'b00000;
    applyStimulus(8);
    checkOutput("glitch_final_level", 32'(bif.btn_level), 32'h0);

    // Simultaneous left + down
    bif.btn_raw = 5'b00110;
    applyStimulus(6);
    checkOutput("simul_press_early", 32'(bif.btn_press), 32'h0);
    applyStimulus(1);
    checkOutput("simul_press", 32'(bif.btn_press), 32'h06);
    applyStimulus(1);
    checkOutput("simul_level", 32'(bif.btn_level), 32'h06);
    checkOutput("simul_any",   32'(bif.any_level), 32'h1);
    bif.btn_raw = 5'b00100;
    applyStimulus(8);
    checkOutput("simul_half_level", 32'(bif.btn_level), 32'h04);
    checkOutput("simul_half_any",   32'(bif.any_level), 32'h1);
    bif.btn_raw = 5'b00000;
    applyStimulus(8);
    checkOutput("simul_done_level", 32'(bif.btn_level), 32'h0);
    checkOutput("simul_done_any",   32'(bif.any_level), 32'h0);

    // Reset two cycles into CHK_HI
    snap_p = press_cnt[0];
    bif.btn_raw = 5'b00001;
    applyStimulus(5);
    rst = 1'b0;
    applyStimulus(1);
    checkOutput("midrst_press", 32'(bif.btn_press), 32'h0);
    checkOutput("midrst_level", 32'(bif.btn_level), 32'h0);
    applyStimulus(2);
    rst = 1'b1;
    applyStimulus(6);
    checkOutput("midrst_lost", 32'(press_cnt[0] - snap_p), 32'd0);
    applyStimulus(1);
    checkOutput("midrst_fresh_press", 32'(bif.btn_press), 32'h01);
    applyStimulus(1);
    checkOutput("midrst_fresh_level", 32'(bif.btn_level), 32'h01);
    checkOutput("midrst_press_once",  32'(press_cnt[0] - snap_p), 32'd1);
    bif.btn_raw = 5'b00000;
    applyStimulus(8);

    // Reset while a press pulse is high
    bif.btn_raw = 5'b10000;
    applyStimulus(7);
    checkOutput("pulse_rst_before", 32'(bif.btn_press), 32'h10);
    rst = 1'b0;
    #1;
    checkOutput("pulse_rst_drop",  32'(bif.btn_press), 32'h0);
    checkOutput("pulse_rst_level", 32'(bif.btn_level), 32'h0);
    applyStimulus(1);
    rst = 1'b1;
    applyStimulus(7);
    checkOutput("pulse_rst_fresh", 32'(bif.btn_press), 32'h10);
    bif.btn_raw = 5'b00000;
    applyStimulus(8);
    checkOutput("pulse_rst_end_any", 32'(bif.any_level), 32'h0);

    checkOutput("press_release_overlap", 32'(overlap), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
